// File: rtl/stage_reg_skid_pkg.sv
// rtl/stage_reg_skid_pkg.sv - shared state encoding and reset constant for the skid stage register
package stage_reg_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_RESET_DATA = 32'h0000_2000;

    function automatic logic [1:0] occ_of(state_e s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stage_reg_skid.sv
// rtl/stage_reg_skid.sv - two-entry skid pipeline register with registered in_ready and flush
module stage_reg_skid
    import stage_reg_skid_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(DEFAULT_RESET_DATA)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, out_valid_q;
    logic [1:0]       occ_q;
    logic             accept, emit;

    assign accept = in_valid && in_ready_q;
    assign emit   = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush clears only the valid state; payload registers keep their contents.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_DATA;
            skid_q      <= RESET_DATA;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            occ_q       <= occ_of(state_d);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_stage_reg_skid.sv
// tb/tb_stage_reg_skid.sv - scoreboard bench for stage_reg_skid with a queue reference model
module tb_stage_reg_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] last_head;

    stage_reg_skid dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model is updated just after the rising edge.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic acc;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc = !reset && iv && (exp_q.size() < 2) && !fl;
        @(posedge clk);
        #1;
        if (!reset) begin
            if (fl) exp_q.delete();
            else if (acc) exp_q.push_back(d);
        end
    endtask

    // Monitor: samples one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!reset) begin
            chk("mon_occupancy", {30'd0, occupancy}, exp_q.size());
            chk("mon_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
            chk("mon_in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
            if (exp_q.size() > 0) begin
                last_head = exp_q[0];
                chk("mon_out_data", out_data, exp_q[0]);
                if (out_valid && out_ready) begin
                    chk("mon_emit_data", out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("mon_held_data", out_data, last_head);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        last_head = 32'h0000_2000;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0000_2000);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        #5 reset = 1'b0;

        // Streaming
        cycle(1, 32'h10, 1, 0);
        chk("stream_d0", out_data, 32'h10);
        cycle(1, 32'h14, 1, 0);
        chk("stream_d1", out_data, 32'h14);
        chk("stream_occ", {30'd0, occupancy}, 32'd1);
        cycle(1, 32'h18, 1, 0);
        chk("stream_d2", out_data, 32'h18);
        cycle(0, 32'h0, 1, 0);

        // Backpressure
        cycle(1, 32'hA, 0, 0);
        cycle(1, 32'hB, 0, 0);
        chk("bp_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        cycle(1, 32'hC, 0, 0);
        chk("bp_held_head", out_data, 32'hA);
        out_ready = 1'b1;
        #1;
        chk("bp_no_comb_path", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b0;
        cycle(1, 32'hC, 1, 0);
        chk("bp_after_emit", out_data, 32'hB);
        cycle(1, 32'hC, 1, 0);
        chk("bp_last", out_data, 32'hC);
        cycle(0, 32'h0, 1, 0);

        // Flush from FULL with a concurrent offer
        cycle(1, 32'hA, 0, 0);
        cycle(1, 32'hB, 0, 0);
        cycle(1, 32'hC, 0, 1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_data", out_data, 32'hA);
        cycle(0, 32'h0, 1, 0);

        // Simultaneous accept and emit in ONE
        cycle(1, 32'h20, 0, 0);
        cycle(1, 32'h24, 1, 0);
        chk("simul_occ", {30'd0, occupancy}, 32'd1);
        chk("simul_data", out_data, 32'h24);
        cycle(0, 32'h0, 1, 0);

        // Reset mid-operation from FULL
        cycle(1, 32'h1, 0, 0);
        cycle(1, 32'h2, 0, 0);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        last_head = 32'h0000_2000;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", out_data, 32'h0000_2000);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        cycle(1, 32'h55, 1, 0);
        #1 reset = 1'b0;
        #1;
        chk("rst_hold_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_hold_data", out_data, 32'h0000_2000);
        cycle(1, 32'h66, 0, 0);
        chk("first_accept", out_data, 32'h66);
        cycle(0, 32'h0, 1, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
        end
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
